// File: rtl/csa_resolve.sv
// Chunk-serial carry-propagate resolver for a carry-save (sum, carry) pair.
// Adds W bits per clock and returns the binary result through a valid/ready handshake.
module csa_resolve #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_sum,
   input  logic [N-1:0]   in_carry,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N+1:0]   result,
   output logic           busy
);

   localparam int M  = N + 2;
   localparam int K  = M / W;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   generate
      if ((M % W) != 0) begin : g_bad_chunk_width
         $error("csa_resolve: N+2 must be divisible by W");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [M-1:0]    r_a;
   logic [M-1:0]    r_b;
   logic [M-1:0]    r_result;
   logic [CW-1:0]   r_cnt;
   logic            r_carry;
   logic            r_in_ready;
   logic            r_out_valid;
   logic            r_busy;
   logic            w_accept;
   logic            w_last;
   logic [W:0]      w_chunk_sum;

   // Acceptance also requires the registered in_ready, so the first edge after reset never captures.
   assign w_accept    = (r_state == S_IDLE) && r_in_ready && in_valid;
   assign w_last      = (r_cnt == CW'(K - 1));
   assign w_chunk_sum = {1'b0, r_a[W-1:0]} + {1'b0, r_b[W-1:0]} + {{W{1'b0}}, r_carry};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         r_state <= w_state_next;
      end
   end

   always_comb begin
      // NOTE: default assigned first so no path leaves the next state unassigned (no latch).
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)  w_state_next = S_BUSY;
         S_BUSY:  if (w_last)    w_state_next = S_DONE;
         S_DONE:  if (out_ready) w_state_next = S_IDLE;
         default:                w_state_next = S_IDLE;
      endcase
   end

   // Status outputs are decoded from the next state so they are registered yet track the state exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_in_ready  <= (w_state_next == S_IDLE);
         r_busy      <= (w_state_next == S_BUSY);
         r_out_valid <= (w_state_next == S_DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
      end else if (w_accept) begin
         r_a     <= {2'b00, in_sum};
         r_b     <= {1'b0, in_carry, 1'b0};
         r_cnt   <= '0;
         r_carry <= 1'b0;
      end else if (r_state == S_BUSY) begin
         // Operands shift down so the adder always sees the current chunk in the low W bits.
         for (int k = 0; k < K; k++) begin
            if (r_cnt == CW'(k)) begin
               r_result[k*W +: W] <= w_chunk_sum[W-1:0];
            end
         end
         r_a     <= r_a >> W;
         r_b     <= r_b >> W;
         r_carry <= w_chunk_sum[W];
         r_cnt   <= r_cnt + CW'(1);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign result    = r_result;

endmodule

// File: tb/tb_csa_resolve.sv
// Self-checking bench for csa_resolve: three instances (W=2, W=1, W=6) with N=4,
// directed handshake/reset scenarios, random pairs and an exhaustive sweep against sum + 2*carry.
module tb_csa_resolve;

   localparam int N  = 4;
   localparam int ND = 3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   in_sum;
   logic [N-1:0]   in_carry;
   logic           in_valid  [ND];
   logic           out_ready [ND];
   logic           in_ready  [ND];
   logic           out_valid [ND];
   logic [N+1:0]   result    [ND];
   logic           busy      [ND];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   csa_resolve #(.N(N), .W(2)) u_w2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .result(result[0]), .busy(busy[0])
   );

   csa_resolve #(.N(N), .W(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .result(result[1]), .busy(busy[1])
   );

   csa_resolve #(.N(N), .W(6)) u_w6 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .result(result[2]), .busy(busy[2])
   );

   // Expected latency in clock edges: (N+2)/W for each instance.
   function automatic int lat_of(input int d);
      case (d)
         0:       return 3;
         1:       return 6;
         default: return 1;
      endcase
   endfunction

   function automatic int model(input logic [N-1:0] s, input logic [N-1:0] c);
      return int'(s) + 2 * int'(c);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input int d);
      int n = 0;
      while (in_ready[d] !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("wait_in_ready", 32'(in_ready[d]), 32'd1);
   endtask

   task automatic accept(input int d, input logic [N-1:0] s, input logic [N-1:0] c);
      wait_ready(d);
      in_sum      = s;
      in_carry    = c;
      in_valid[d] = 1'b1;
      tick();
      in_valid[d] = 1'b0;
      check("accept_busy", 32'(busy[d]), 32'd1);
      check("accept_in_ready", 32'(in_ready[d]), 32'd0);
   endtask

   // Called just after the accepting edge; counts edges until out_valid rises.
   task automatic wait_result(input int d, input int exp, input string tag);
      int n = 0;
      do begin
         tick();
         n++;
         if (out_valid[d] !== 1'b1) check({tag, "_busy"}, 32'(busy[d]), 32'd1);
      end while (out_valid[d] !== 1'b1 && n < 40);
      check({tag, "_latency"}, 32'(n), 32'(lat_of(d)));
      check({tag, "_out_valid"}, 32'(out_valid[d]), 32'd1);
      check({tag, "_busy_done"}, 32'(busy[d]), 32'd0);
      check({tag, "_result"}, 32'(result[d]), 32'(exp));
   endtask

   task automatic handshake(input int d, input int exp);
      out_ready[d] = 1'b1;
      tick();
      out_ready[d] = 1'b0;
      check("hs_out_valid", 32'(out_valid[d]), 32'd0);
      check("hs_in_ready", 32'(in_ready[d]), 32'd1);
      check("hs_result_held", 32'(result[d]), 32'(exp));
   endtask

   task automatic run_txn(input int d, input logic [N-1:0] s, input logic [N-1:0] c,
                          input int exp, input string tag);
      accept(d, s, c);
      wait_result(d, exp, tag);
      handshake(d, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] s;
      logic [N-1:0] c;
      logic [N-1:0] s2;
      logic [N-1:0] c2;
      int           exp;
      int           seen;
      int           d;

      rst_n    = 1'b0;
      in_sum   = '0;
      in_carry = '0;
      for (int i = 0; i < ND; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b0;
      end

      // Reset held three cycles with random inputs.
      repeat (3) begin
         in_sum   = N'($urandom);
         in_carry = N'($urandom);
         for (int i = 0; i < ND; i++) begin
            in_valid[i]  = 1'($urandom);
            out_ready[i] = 1'($urandom);
         end
         tick();
         for (int i = 0; i < ND; i++) begin
            check("rst_out_valid", 32'(out_valid[i]), 32'd0);
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_in_ready", 32'(in_ready[i]), 32'd0);
            check("rst_result", 32'(result[i]), 32'd0);
         end
      end
      for (int i = 0; i < ND; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b0;
      end
      rst_n = 1'b1;
      #2;
      check("release_in_ready_low", 32'(in_ready[0]), 32'd0);
      tick();
      for (int i = 0; i < ND; i++) check("release_in_ready_high", 32'(in_ready[i]), 32'd1);

      // Directed values.
      run_txn(0, 4'b0000, 4'b1110, 28, "basic");
      run_txn(0, 4'b1111, 4'b1111, 45, "max");
      run_txn(0, 4'b0000, 4'b0000, 0, "zero");

      // Backpressure, ignored in_valid in DONE, and in_valid held across the handshake edge.
      s   = N'($urandom);
      c   = N'($urandom);
      exp = model(s, c);
      s2  = ~s;
      c2  = ~c;
      accept(0, s, c);
      wait_result(0, exp, "bp");
      repeat (5) begin
         in_sum      = s2;
         in_carry    = c2;
         in_valid[0] = 1'b1;
         tick();
         check("bp_out_valid_held", 32'(out_valid[0]), 32'd1);
         check("bp_result_held", 32'(result[0]), 32'(exp));
         check("bp_in_ready", 32'(in_ready[0]), 32'd0);
         check("bp_busy", 32'(busy[0]), 32'd0);
      end
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
      check("bp_hs_out_valid", 32'(out_valid[0]), 32'd0);
      check("bp_hs_in_ready", 32'(in_ready[0]), 32'd1);
      check("bp_hs_not_accepted", 32'(busy[0]), 32'd0);
      check("bp_hs_result", 32'(result[0]), 32'(exp));
      tick();
      in_valid[0] = 1'b0;
      check("bp_next_busy", 32'(busy[0]), 32'd1);
      check("bp_next_in_ready", 32'(in_ready[0]), 32'd0);
      wait_result(0, model(s2, c2), "bp_next");
      handshake(0, model(s2, c2));

      // Asynchronous reset while chunk 1 is being resolved.
      accept(0, 4'b1010, 4'b0101);
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy[0]), 32'd0);
      check("abort_out_valid", 32'(out_valid[0]), 32'd0);
      check("abort_in_ready", 32'(in_ready[0]), 32'd0);
      check("abort_result", 32'(result[0]), 32'd0);
      #2 rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         tick();
         if (out_valid[0] !== 1'b0) seen++;
      end
      check("abort_no_out_valid", 32'(seen), 32'd0);
      run_txn(0, 4'b1001, 4'b0110, 21, "after_abort");

      // Random pairs on random instances.
      repeat (30) begin
         d = int'($urandom_range(0, ND - 1));
         s = N'($urandom);
         c = N'($urandom);
         run_txn(d, s, c, model(s, c), "random");
      end

      // Exhaustive sweep of every (sum, carry) pair for each chunk width.
      for (int i = 0; i < ND; i++) begin
         for (int sv = 0; sv < 16; sv++) begin
            for (int cv = 0; cv < 16; cv++) begin
               run_txn(i, N'(sv), N'(cv), sv + 2 * cv, "sweep");
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
